// File: rtl/mul_issue.sv
// Issue/response stage around an external combinational multiplier: registers the
// operands, pipelines the product to writeback over LATENCY cycles, reports in-flight rd.
module mul_issue #(
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rdata1,
    input  logic [31:0] req_rdata2,
    input  logic [4:0]  req_waddr,
    output logic [31:0] mul_rdata1,
    output logic [31:0] mul_rdata2,
    output logic [3:0]  mul_op,
    input  logic [31:0] mul_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_waddr,
    input  logic [4:0]  chk_waddr,
    output logic        chk_hit
);

    localparam int L = LATENCY;

    logic            stall;
    logic            accept;
    logic [L:1]      valid_q, valid_d;
    logic [L:1][4:0] waddr_q, waddr_d;
    logic [31:0]     op1_q, op1_d;
    logic [31:0]     op2_q, op2_d;
    logic [3:0]      op_q, op_d;

    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        return 4'b0001 << op;
    endfunction

    assign rsp_valid = valid_q[L];
    assign rsp_waddr = waddr_q[L];
    assign stall     = rsp_valid & ~rsp_ready;
    assign req_ready = ~reset & ~flush & ~stall;
    assign accept    = req_valid & req_ready;

    assign mul_rdata1 = op1_q;
    assign mul_rdata2 = op2_q;
    assign mul_op     = valid_q[1] ? op_q : 4'b0000;

    // A stall freezes every stage, empty ones included, so bubbles never compress.
    always_comb begin
        valid_d = valid_q;
        waddr_d = waddr_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        op_d    = op_q;
        if (!stall) begin
            valid_d[1] = accept;
            waddr_d[1] = accept ? req_waddr : 5'd0;
            for (int k = 2; k <= L; k++) begin
                valid_d[k] = valid_q[k-1];
                waddr_d[k] = waddr_q[k-1];
            end
            if (accept) begin
                op1_d = req_rdata1;
                op2_d = req_rdata2;
                op_d  = op_onehot(req_op);
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            waddr_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            op_q    <= '0;
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        chk_hit = 1'b0;
        for (int k = 1; k <= L; k++) begin
            if (valid_q[k] && (waddr_q[k] == chk_waddr)) begin
                chk_hit = 1'b1;
            end
        end
        if (chk_waddr == 5'd0) begin
            chk_hit = 1'b0;
        end
    end

    generate
        if (L == 1) begin : g_comb_rsp
            assign rsp_result = valid_q[1] ? mul_result : 32'd0;
        end else begin : g_reg_rsp
            // data_q[j] holds the product for stage j+1; bubbles carry zero.
            logic [L-1:1][31:0] data_q, data_d;

            always_comb begin
                data_d = data_q;
                if (!stall) begin
                    data_d[1] = valid_q[1] ? mul_result : 32'd0;
                    for (int j = 2; j <= L - 1; j++) begin
                        data_d[j] = data_q[j-1];
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign rsp_result = data_q[L-1];
        end
    endgenerate

endmodule

// File: tb/tb_mul_issue.sv
// Directed bench for mul_issue (LATENCY=2) with a behavioural multiplier on the mul_* side.
module tb_mul_issue;

    logic        clock = 1'b0;
    logic        reset, flush, req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rdata1, req_rdata2;
    logic [4:0]  req_waddr;
    logic [31:0] mul_rdata1, mul_rdata2, mul_result;
    logic [3:0]  mul_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_waddr, chk_waddr;
    logic        chk_hit;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mul_issue #(.LATENCY(2)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rdata1(req_rdata1), .req_rdata2(req_rdata2), .req_waddr(req_waddr),
        .mul_rdata1(mul_rdata1), .mul_rdata2(mul_rdata2), .mul_op(mul_op),
        .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_waddr(rsp_waddr),
        .chk_waddr(chk_waddr), .chk_hit(chk_hit)
    );

    // Reference multiplier: modular 64-bit products of extended operands.
    logic [63:0] p_ss, p_su, p_uu;
    always_comb begin
        p_ss = {{32{mul_rdata1[31]}}, mul_rdata1} * {{32{mul_rdata2[31]}}, mul_rdata2};
        p_su = {{32{mul_rdata1[31]}}, mul_rdata1} * {32'd0, mul_rdata2};
        p_uu = {32'd0, mul_rdata1} * {32'd0, mul_rdata2};
        case (mul_op)
            4'b0001: mul_result = p_uu[31:0];
            4'b0010: mul_result = p_ss[63:32];
            4'b0100: mul_result = p_su[63:32];
            4'b1000: mul_result = p_uu[63:32];
            default: mul_result = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] w);
        req_valid  = 1'b1;
        req_op     = op;
        req_rdata1 = a;
        req_rdata2 = b;
        req_waddr  = w;
    endtask

    task automatic rsp(input string tag, input logic [31:0] res, input logic [4:0] w);
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_result"}, rsp_result, res);
        chk({tag, "_waddr"}, {27'd0, rsp_waddr}, {27'd0, w});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'd0;
        req_rdata1 = '0; req_rdata2 = '0; req_waddr = '0;
        rsp_ready = 1'b1; chk_waddr = 5'd0;
        step(); step();

        // reset state
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_mul_op", {28'd0, mul_op}, 32'd0);
        chk("rst_req_ready_in_reset", {31'd0, req_ready}, 32'd0);
        reset = 1'b0; #1;
        chk("rst_req_ready_after", {31'd0, req_ready}, 32'd1);

        // 1: MUL latency
        issue(2'd0, 32'd7, 32'hFFFFFFFD, 5'd3);
        step();
        req_valid = 1'b0; #1;
        chk("t1_mul_op", {28'd0, mul_op}, 32'h1);
        chk("t1_mul_rdata1", mul_rdata1, 32'd7);
        chk("t1_not_yet", {31'd0, rsp_valid}, 32'd0);
        step();
        rsp("t1", 32'hFFFFFFEB, 5'd3);
        step();
        chk("t1_drained", {31'd0, rsp_valid}, 32'd0);

        // 2: high-half variants back to back
        issue(2'd1, 32'h80000000, 32'h80000000, 5'd1);
        step();
        issue(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
        step();
        rsp("t2_mulh", 32'h40000000, 5'd1);
        issue(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
        step();
        rsp("t2_mulhu", 32'hFFFFFFFE, 5'd2);
        req_valid = 1'b0;
        step();
        rsp("t2_mulhsu", 32'hFFFFFFFF, 5'd4);
        step();
        chk("t2_drained", {31'd0, rsp_valid}, 32'd0);

        // 3: four ops with a three-cycle writeback stall
        issue(2'd0, 32'd1, 32'd10, 5'd10);
        step();
        issue(2'd0, 32'd2, 32'd10, 5'd11);
        step();
        issue(2'd0, 32'd3, 32'd10, 5'd12);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_ready", {31'd0, req_ready}, 32'd0);
            rsp("t3_stall_hold", 32'd10, 5'd10);
            chk("t3_stall_s1", mul_rdata1, 32'd2);
            step();
        end
        rsp_ready = 1'b1; #1;
        chk("t3_ready_back", {31'd0, req_ready}, 32'd1);
        rsp("t3_r0", 32'd10, 5'd10);
        step();
        rsp("t3_r1", 32'd20, 5'd11);
        issue(2'd0, 32'd4, 32'd10, 5'd13);
        step();
        rsp("t3_r2", 32'd30, 5'd12);
        req_valid = 1'b0;
        step();
        rsp("t3_r3", 32'd40, 5'd13);
        step();
        chk("t3_drained", {31'd0, rsp_valid}, 32'd0);

        // 4: flush with two ops in flight and a new request
        issue(2'd0, 32'd5, 32'd5, 5'd6);
        step();
        issue(2'd0, 32'd6, 32'd6, 5'd7);
        step();
        issue(2'd0, 32'd9, 32'd9, 5'd8);
        chk_waddr = 5'd7;
        flush = 1'b1; #1;
        chk("t4_hit_before", {31'd0, chk_hit}, 32'd1);
        chk("t4_req_ready_flush", {31'd0, req_ready}, 32'd0);
        step();
        flush = 1'b0; req_valid = 1'b0; #1;
        chk("t4_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t4_chk_hit", {31'd0, chk_hit}, 32'd0);
        chk("t4_mul_op", {28'd0, mul_op}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_never_appears", {31'd0, rsp_valid}, 32'd0);
        end

        // 5: scoreboard hit on rd 5, none for rd 0
        issue(2'd0, 32'd3, 32'd3, 5'd5);
        chk_waddr = 5'd5;
        step();
        req_valid = 1'b0; #1;
        chk("t5_hit_s1", {31'd0, chk_hit}, 32'd1);
        step();
        chk("t5_hit_s2", {31'd0, chk_hit}, 32'd1);
        rsp("t5_rsp", 32'd9, 5'd5);
        step();
        chk("t5_hit_retired", {31'd0, chk_hit}, 32'd0);
        issue(2'd0, 32'd4, 32'd4, 5'd0);
        chk_waddr = 5'd0;
        step();
        req_valid = 1'b0; #1;
        chk("t5_x0_nohit", {31'd0, chk_hit}, 32'd0);
        step();
        rsp("t5_x0_rsp", 32'd16, 5'd0);
        step();

        // 6: reset with a full, stalled pipeline
        issue(2'd0, 32'd8, 32'd8, 5'd9);
        step();
        issue(2'd0, 32'd2, 32'd2, 5'd10);
        rsp_ready = 1'b0;
        chk_waddr = 5'd9;
        step();
        rsp("t6_full", 32'd64, 5'd9);
        reset = 1'b1;
        step();
        chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_rsp_result", rsp_result, 32'd0);
        chk("t6_rsp_waddr", {27'd0, rsp_waddr}, 32'd0);
        chk("t6_mul_rdata1", mul_rdata1, 32'd0);
        chk("t6_mul_rdata2", mul_rdata2, 32'd0);
        chk("t6_mul_op", {28'd0, mul_op}, 32'd0);
        chk("t6_chk_hit", {31'd0, chk_hit}, 32'd0);
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; #1;
        chk("t6_req_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("t6_stays_empty", {31'd0, rsp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
